// File: rtl/conv_pkg.sv
// conv_pkg: shared types and configuration for the convolution window fetcher.
//   - state_e        : fetcher FSM states
//   - *_DFLT         : default image/kernel geometry
//   - OUT_W, OUT_H   : window grid size for the default geometry
//   - TAPS, TAP_W    : taps per window and tap-index width
//   - out_dim()      : window count along one axis for a given geometry
// Build option: CONV_ZERO_PAD_EN selects "same" zero padding (origins start
// at -(K/2)); undefined gives "valid" convolution.
package conv_pkg;

  localparam int IMG_W_DFLT  = 32;
  localparam int IMG_H_DFLT  = 24;
  localparam int K_DFLT      = 3;
  localparam int STRIDE_DFLT = 1;

`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DRAIN   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Windows along one axis; pad widens the extent on both sides.
  function automatic int out_dim(input int img, input int k, input int s, input int pad);
    return (img + 2 * pad - k) / s + 1;
  endfunction

  localparam int PAD_DFLT = PAD_EN ? (K_DFLT / 2) : 0;
  localparam int OUT_W    = out_dim(IMG_W_DFLT, K_DFLT, STRIDE_DFLT, PAD_DFLT);
  localparam int OUT_H    = out_dim(IMG_H_DFLT, K_DFLT, STRIDE_DFLT, PAD_DFLT);
  localparam int TAPS     = K_DFLT * K_DFLT;
  localparam int TAP_W    = $clog2(TAPS);

endpackage

// File: rtl/conv_rd_delay.sv
// conv_rd_delay: fixed-latency shift register that tracks in-flight buffer
// reads so each returning data byte can be matched to its window tap.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   push     : entry issued this cycle {valid, tap[, pad]}
//   pop      : entry issued RD_LAT cycles earlier
module conv_rd_delay
  import conv_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int EW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [EW-1:0] push,
  output logic [EW-1:0] pop
);

  logic [EW-1:0] stage [RD_LAT];

  // Shift every stage by one each cycle; no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) stage[s] <= '0;
    end else begin
      stage[0] <= push;
      for (int s = 1; s < RD_LAT; s++) stage[s] <= stage[s-1];
    end
  end

  assign pop = stage[RD_LAT-1];

endmodule

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks a KxK window over the image held in the read bank
// of the input ping-pong buffer, one read per cycle, assembles each window
// and hands it to the PE array over valid/ready, then pulses o_done.
//   i_clk, i_rst  : clock, asynchronous active-high reset (aborts a frame)
//   i_start       : read bank full, begin a frame (ignored while busy)
//   o_busy        : frame in progress
//   o_done        : one-cycle pulse after the last window is accepted
//   o_conv_addr   : buffer read address (held outside FETCH)
//   i_conv_dout   : buffer read data, RD_LAT cycles after the address
//   o_win_data    : window, tap t=i*K+j at [t*DW +: DW], t=0 top-left
//   o_win_vld     : window valid, held with data until i_win_rdy
//   i_win_rdy     : consumer ready
// Build option: CONV_ZERO_PAD_EN enables "same" zero padding.
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DFLT,
  parameter int IMG_H  = IMG_H_DFLT,
  parameter int K      = K_DFLT,
  parameter int STRIDE = STRIDE_DFLT,
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [AW-1:0]     o_conv_addr,
  input  logic [DW-1:0]     i_conv_dout,
  output logic [K*K*DW-1:0] o_win_data,
  output logic              o_win_vld,
  input  logic              i_win_rdy
);

  localparam int PAD      = PAD_EN ? (K / 2) : 0;
  localparam int NTAPS    = K * K;
  localparam int TW       = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int KW       = $clog2(K + 1);
  localparam int WIN_COLS = out_dim(IMG_W, K, STRIDE, PAD);
  localparam int WIN_ROWS = out_dim(IMG_H, K, STRIDE, PAD);
  localparam int OW       = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + K) + 1;
  localparam int AWP      = AW + 1;

  localparam logic signed [OW-1:0] ORG_FIRST = OW'(-PAD);
  localparam logic signed [OW-1:0] COL_LAST  = OW'((WIN_COLS - 1) * STRIDE - PAD);
  localparam logic signed [OW-1:0] ROW_LAST  = OW'((WIN_ROWS - 1) * STRIDE - PAD);
  localparam logic [TW-1:0]        TAP_LAST  = TW'(NTAPS - 1);
  localparam logic [KW-1:0]        K_LAST    = KW'(K - 1);

`ifdef CONV_ZERO_PAD_EN
  localparam int EW = 1 + TW + 1;
`else
  localparam int EW = 1 + TW;
`endif

  state_e state, state_nxt;

  logic signed [OW-1:0] r0, c0, row, col;
  logic [TW-1:0]        tap_cnt, iss_tap, pop_tap;
  logic [KW-1:0]        tap_i, tap_j;
  logic [AW-1:0]        addr_nxt;
  logic                 iss_vld, pop_vld, last_win;
  logic [DW-1:0]        cap_byte;
  logic [EW-1:0]        push_entry, pop_entry;
`ifdef CONV_ZERO_PAD_EN
  logic                 tap_pad, iss_pad, pop_pad;
  assign push_entry = {iss_vld, iss_tap, iss_pad};
  assign {pop_vld, pop_tap, pop_pad} = pop_entry;
`else
  assign push_entry = {iss_vld, iss_tap};
  assign {pop_vld, pop_tap} = pop_entry;
`endif

  conv_rd_delay #(.RD_LAT(RD_LAT), .EW(EW)) u_rd_delay (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (push_entry),
    .pop  (pop_entry)
  );

  // Tap coordinates, read address and capture value for the current tap.
  always_comb begin
    row = r0 + $signed(OW'(tap_i));
    col = c0 + $signed(OW'(tap_j));
    // Unsigned at AW+1 bits, then truncated to the buffer address width.
    addr_nxt = AW'(AWP'($unsigned(row)) * AWP'(IMG_W) + AWP'($unsigned(col)));
    cap_byte = i_conv_dout;
`ifdef CONV_ZERO_PAD_EN
    // Negative coordinates wrap to large unsigned values, so one compare per axis.
    tap_pad = ($unsigned(row) >= OW'(IMG_H)) || ($unsigned(col) >= OW'(IMG_W));
    if (tap_pad) begin
      addr_nxt = '0;
    end else begin
      addr_nxt = addr_nxt;
    end
    if (pop_pad) begin
      cap_byte = '0;
    end else begin
      cap_byte = i_conv_dout;
    end
`endif
    last_win = (c0 == COL_LAST) && (r0 == ROW_LAST);
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_FETCH;
        else         state_nxt = S_IDLE;
      end
      S_FETCH: begin
        if (tap_cnt == TAP_LAST) state_nxt = S_DRAIN;
        else                     state_nxt = S_FETCH;
      end
      S_DRAIN: begin
        if (pop_vld && (pop_tap == TAP_LAST)) state_nxt = S_PRESENT;
        else                                  state_nxt = S_DRAIN;
      end
      S_PRESENT: begin
        if (o_win_vld && i_win_rdy) begin
          if (last_win) state_nxt = S_DONE;
          else          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_PRESENT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: origin/tap counters, address issue, tap capture, status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_conv_addr <= '0;
      o_win_data  <= '0;
      o_win_vld   <= 1'b0;
      r0          <= '0;
      c0          <= '0;
      tap_cnt     <= '0;
      tap_i       <= '0;
      tap_j       <= '0;
      iss_vld     <= 1'b0;
      iss_tap     <= '0;
`ifdef CONV_ZERO_PAD_EN
      iss_pad     <= 1'b0;
`endif
    end else begin
      o_done  <= (state_nxt == S_DONE);
      o_busy  <= (state_nxt == S_FETCH) || (state_nxt == S_DRAIN) ||
                 (state_nxt == S_PRESENT);
      iss_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            r0 <= ORG_FIRST;
            c0 <= ORG_FIRST;
          end
        end
        S_FETCH: begin
          o_conv_addr <= addr_nxt;
          iss_vld     <= 1'b1;
          iss_tap     <= tap_cnt;
`ifdef CONV_ZERO_PAD_EN
          iss_pad     <= tap_pad;
`endif
          if (tap_cnt == TAP_LAST) begin
            tap_cnt <= '0;
            tap_i   <= '0;
            tap_j   <= '0;
          end else begin
            tap_cnt <= tap_cnt + TW'(1);
            if (tap_j == K_LAST) begin
              tap_j <= '0;
              tap_i <= tap_i + KW'(1);
            end else begin
              tap_j <= tap_j + KW'(1);
            end
          end
        end
        S_PRESENT: begin
          if (o_win_vld && i_win_rdy) begin
            o_win_vld <= 1'b0;
            if (c0 == COL_LAST) begin
              c0 <= ORG_FIRST;
              if (r0 != ROW_LAST) r0 <= r0 + OW'(STRIDE);
            end else begin
              c0 <= c0 + OW'(STRIDE);
            end
          end
        end
        default: ;
      endcase
      // Returning reads land in their tap slot as they emerge from the delay line.
      if (pop_vld) o_win_data[int'(pop_tap)*DW +: DW] <= cap_byte;
      if ((state == S_DRAIN) && pop_vld && (pop_tap == TAP_LAST)) o_win_vld <= 1'b1;
    end
  end

endmodule
